bta_serial_sched: RTL and testbench



---
 rtl/bta_serial_sched.sv | 135 +++++++++++++
 tb/tb_bta_serial_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bta_serial_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bta_serial_sched: N-operand binary-tree sum through one shared adder.      |
// | Optional BTA_SIGNED_EN: sign-extend operands. Rev 1.0                      |
// +----------------------------------------------------------------------------+
module bta_serial_sched #(
   parameter int N = 8,
   parameter int M = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [M-1:0]                 in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [M+$clog2(N)-1:0]       out_sum,
   output logic                         busy,
   output logic [$clog2(N):0]           op_count
);
   localparam int LOG2N = $clog2(N);
   localparam int c_W   = M + LOG2N;
   localparam int c_LVW = $clog2(LOG2N + 1);
   localparam logic [LOG2N:0]   c_LAST_CNT = (LOG2N + 1)'(N - 1);
   localparam logic [LOG2N-1:0] c_ONE      = LOG2N'(1);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [c_W-1:0]     r_buf [N];
   logic [LOG2N:0]     r_count;
   logic [c_LVW-1:0]   r_level;
   logic [LOG2N-1:0]   r_k;
   logic               r_out_valid;
   logic [c_W-1:0]     r_out_sum;

   logic               w_accept;
   logic [LOG2N-1:0]   w_lo;
   logic [LOG2N-1:0]   w_hi;
   logic [LOG2N-1:0]   w_half;
   logic               w_k_last;
   logic               w_lvl_last;
   logic [c_W-1:0]     w_ext;

`ifdef BTA_SIGNED_EN
   assign w_ext = {{LOG2N{in_data[M-1]}}, in_data};
`else
   assign w_ext = {{LOG2N{1'b0}}, in_data};
`endif

   // Pair k of level L combines slots k*2^L and k*2^L + 2^(L-1).
   assign w_lo       = r_k << r_level;
   assign w_half     = c_ONE << (r_level - c_LVW'(1));
   assign w_hi       = w_lo + w_half;
   assign w_k_last   = (r_k == LOG2N'((N >> r_level) - 1));
   assign w_lvl_last = (r_level == c_LVW'(LOG2N));
   assign w_accept   = in_valid && (r_state == ST_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_LOAD;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_LOAD:   if (w_accept && (r_count == c_LAST_CNT)) w_next = ST_REDUCE;
         ST_REDUCE: if (w_k_last && w_lvl_last)              w_next = ST_DONE;
         ST_DONE:   if (r_out_valid && out_ready)            w_next = ST_LOAD;
         default:   w_next = ST_LOAD;
      endcase
      if (clear) w_next = ST_LOAD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r_buf[i] <= '0;
         r_count     <= '0;
         r_level     <= c_LVW'(1);
         r_k         <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
      end else if (clear) begin
         r_count     <= '0;
         r_level     <= c_LVW'(1);
         r_k         <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               r_level <= c_LVW'(1);
               r_k     <= '0;
               if (w_accept) begin
                  r_buf[r_count[LOG2N-1:0]] <= w_ext;
                  r_count                   <= r_count + 1'b1;
               end
            end
            ST_REDUCE: begin
               r_buf[w_lo] <= r_buf[w_lo] + r_buf[w_hi];
               if (w_k_last) begin
                  r_k     <= '0;
                  r_level <= r_level + c_LVW'(1);
               end else begin
                  r_k <= r_k + c_ONE;
               end
            end
            ST_DONE: begin
               // First DONE cycle transfers the finished slot 0 to the output.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_sum   <= r_buf[0];
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_count     <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_LOAD);
   assign busy      = (r_state == ST_REDUCE) || (r_state == ST_DONE);
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign op_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bta_serial_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bta_serial_sched: randomized scoreboard bench for bta_serial_sched.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_bta_serial_sched;
   localparam int N = 8;
   localparam int M = 16;
   localparam int W = M + 3;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, in_ready, out_valid, out_ready, busy;
   logic [M-1:0]  in_data;
   logic [W-1:0]  out_sum;
   logic [3:0]    op_count;

   typedef struct {
      logic [W-1:0] sum;
      int           rise;
   } exp_t;

   exp_t          sb[$];
   longint        cur_sum = 0;
   int            cur_n = 0;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   bit            force_low = 0;
   bit            rand_ready = 0;
   bit            use_gaps = 0;
   logic [W-1:0]  last_sum = '0;

   bta_serial_sched #(.N(N), .M(M)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint ext(input logic [M-1:0] d);
`ifdef BTA_SIGNED_EN
      return longint'($signed(d));
`else
      return longint'(d);
`endif
   endfunction

   // Reference: a batch sum is the plain sum of its N extended operands, truncated to W bits.
   task automatic send_op(input logic [M-1:0] d);
      int waited = 0;
      @(negedge clk);
      if (use_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
         in_valid = 1'b0;
         return;
      end
      cur_sum += ext(d);
      cur_n++;
      if (cur_n == N) begin
         sb.push_back('{sum: W'(cur_sum), rise: cyc + 1 + N});
         cur_sum = 0;
         cur_n   = 0;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_batch_const(input logic [M-1:0] d);
      for (int i = 0; i < N; i++) send_op(d);
   endtask

   task automatic drain();
      int w = 0;
      while ((sb.size() != 0 || out_valid) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         checks++; errors++;
         $display("FAIL drain_timeout: pending %0d expected 0", sb.size());
      end
   endtask

   // Monitor: drives out_ready and pops/compares on every output handshake.
   initial begin : monitor
      bit           pv;
      bit           took;
      logic [W-1:0] ps;
      pv = 0; took = 0; ps = '0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = force_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
         if (rst) begin
            pv = 0; took = 0;
            continue;
         end
         if (took) chk("valid_one_cycle", out_valid, 0);
         took = 0;
         if (out_valid) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got sum 0x%0h expected no output", out_sum);
            end else begin
               if (!pv) chk("latency", cyc, sb[0].rise);
               else     chk("hold_stable", out_sum, ps);
               if (out_ready) begin
                  chk("sum", out_sum, sb[0].sum);
                  last_sum = out_sum;
                  void'(sb.pop_front());
                  took = 1;
               end
            end
         end
         pv = out_valid;
         ps = out_sum;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      logic [W-1:0] held;
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_out_sum", out_sum, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 1..8 back-to-back
      for (int i = 1; i <= N; i++) send_op(M'(i));
      drain();
      chk("sum_1_to_8", last_sum, 'h24);

      // all-ones then immediate all-ones-LSB batch
      send_batch_const(16'hFFFF);
      send_batch_const(16'h0001);
      drain();
      chk("sum_ones_x8", last_sum, 'h8);

      // backpressure
      force_low = 1;
      for (int i = 0; i < N; i++) send_op(M'($urandom));
      begin
         int w = 0;
         while (!out_valid && w < 100) begin @(negedge clk); w++; end
      end
      held = out_sum;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1);
         chk("bp_sum", out_sum, held);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_op_count", op_count, N);
         in_valid = i[0];
         in_data  = 16'hBEEF;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; force_low = 0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_op_count", op_count, 0);
      drain();

      // clear mid-load, then clear together with an accept
      for (int i = 0; i < 3; i++) send_op(16'h1234);
      @(negedge clk); clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      cur_sum = 0; cur_n = 0;
      @(negedge clk);
      chk("clear_op_count", op_count, 0);
      in_valid = 1'b1; in_data = 16'h0055; clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("clear_accept_op_count", op_count, 0);
      send_batch_const(16'h0002);
      drain();
      chk("sum_after_clear", last_sum, 'h10);

      // reset during REDUCE
      for (int i = 0; i < N; i++) send_op(M'($urandom));
      repeat (3) @(posedge clk);
      #1;
      chk("reduce_busy", busy, 1);
      chk("reduce_in_ready", in_ready, 0);
      rst = 1'b1;
      #1;
      void'(sb.pop_back());
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_op_count", op_count, 0);
      chk("mid_rst_out_sum", out_sum, 0);
      @(negedge clk); rst = 1'b0;
      send_batch_const(16'h0003);
      drain();
      chk("sum_after_rst", last_sum, 'h18);

      // sign-sensitive batch
      for (int i = 0; i < 4; i++) send_op(16'hFFFF);
      for (int i = 0; i < 4; i++) send_op(16'h0001);
      drain();
`ifdef BTA_SIGNED_EN
      chk("sum_mixed", last_sum, 'h00000);
`else
      chk("sum_mixed", last_sum, 'h40000);
`endif

      // randomized batches with gaps and random backpressure
      use_gaps = 1; rand_ready = 1;
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 3))
               0:       send_op(16'hFFFF);
               1:       send_op(16'h8000);
               default: send_op(M'($urandom));
            endcase
         end
      end
      rand_ready = 0;
      drain();
      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
